// File: rtl/periph_test_driver.sv
// periph_test_driver: scripted bus initiator issuing writes, masked read-checks and delays from a script ROM.
module periph_test_driver #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SCRIPT_AW  = 6,
  parameter int TIMEOUT    = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  output logic [SCRIPT_AW-1:0]                  script_addr_o,
  input  logic [2+ADDR_WIDTH+2*DATA_WIDTH-1:0]  script_word_i,
  output logic                                  bus_valid_o,
  output logic                                  bus_read_o,
  output logic                                  bus_write_o,
  output logic [ADDR_WIDTH-1:0]                 bus_addr_o,
  output logic [DATA_WIDTH-1:0]                 bus_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 bus_rdata_i,
  input  logic                                  bus_ack_i,
  output logic                                  done_o,
  output logic                                  error_o,
  output logic                                  timeout_o,
  output logic [SCRIPT_AW-1:0]                  fail_index_o
);
  localparam int SW = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_WRITE = 2'd1, OP_READ = 2'd2, OP_WAIT = 2'd3;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ACK, DELAY, DONE} state_e;
  state_e                 state_q;
  logic [SCRIPT_AW-1:0]   script_addr_q, fail_index_q;
  logic                   bus_valid_q, bus_read_q, bus_write_q, done_q, error_q, timeout_q;
  logic [ADDR_WIDTH-1:0]  bus_addr_q;
  logic [DATA_WIDTH-1:0]  bus_wdata_q, mask_q;
  logic [TW-1:0]          wcnt_q;
  logic [15:0]            dcnt_q;
  logic [1:0]             op;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_data, w_mask;
  logic                   adv_d, mismatch;
  assign op       = script_word_i[SW-1 -: 2];
  assign w_addr   = script_word_i[2*DATA_WIDTH +: ADDR_WIDTH];
  assign w_data   = script_word_i[DATA_WIDTH +: DATA_WIDTH];
  assign w_mask   = script_word_i[DATA_WIDTH-1:0];
  assign mismatch = ((bus_rdata_i ^ bus_wdata_q) & mask_q) != '0;
  // Every path that finishes a step funnels through adv_d so the end-of-ROM rule lives in one place
  assign adv_d = (state_q == FETCH && op == OP_WAIT && w_data[15:0] == 16'd0) ||
                 (state_q == WAIT_ACK && bus_ack_i) ||
                 (state_q == DELAY && dcnt_q == 16'd1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      script_addr_q <= '0;
      fail_index_q  <= '0;
      bus_valid_q   <= 1'b0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      mask_q        <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      timeout_q     <= 1'b0;
      wcnt_q        <= '0;
      dcnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_q       <= FETCH;
          script_addr_q <= '0;
          fail_index_q  <= '0;
          done_q        <= 1'b0;
          error_q       <= 1'b0;
          timeout_q     <= 1'b0;
        end
        FETCH: if (op == OP_WRITE || op == OP_READ) begin
          bus_addr_q  <= w_addr;
          bus_wdata_q <= w_data;
          mask_q      <= w_mask;
          bus_valid_q <= 1'b1;
          bus_write_q <= op == OP_WRITE;
          bus_read_q  <= op == OP_READ;
          wcnt_q      <= '0;
          state_q     <= WAIT_ACK;
        end else if (op == OP_WAIT) begin
          dcnt_q  <= w_data[15:0];
          state_q <= DELAY;
        end else begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        WAIT_ACK: if (bus_ack_i) begin
          bus_valid_q <= 1'b0;
          bus_read_q  <= 1'b0;
          bus_write_q <= 1'b0;
          if (bus_read_q && mismatch) begin
            error_q <= 1'b1;
            if (!error_q) fail_index_q <= script_addr_q;
          end
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          bus_valid_q <= 1'b0;
          bus_read_q  <= 1'b0;
          bus_write_q <= 1'b0;
          error_q     <= 1'b1;
          timeout_q   <= 1'b1;
          done_q      <= 1'b1;
          if (!error_q) fail_index_q <= script_addr_q;
          state_q     <= DONE;
        end else begin
          wcnt_q <= wcnt_q + TW'(1);
        end
        DELAY: dcnt_q <= dcnt_q - 16'd1;
        default: state_q <= IDLE;
      endcase
      if (adv_d) begin
        if (&script_addr_q) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          script_addr_q <= script_addr_q + SCRIPT_AW'(1);
          state_q       <= FETCH;
        end
      end
    end
  end
  assign script_addr_o = script_addr_q;
  assign fail_index_o  = fail_index_q;
  assign bus_valid_o   = bus_valid_q;
  assign bus_read_o    = bus_read_q;
  assign bus_write_o   = bus_write_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign timeout_o     = timeout_q;
endmodule

// File: doc/periph_test_driver.md
# periph_test_driver

Scripted peripheral-bus initiator that exercises one memory-mapped peripheral (counter, GPIO, sync block) and reports a `done`/`error` pair, the same pair the peripheral testbench aggregator reduces. It fetches operations from an external combinational script ROM and issues bus writes, masked read-checks and idle delays. It records the first failing step and stops on a bus timeout. It sits between a script ROM and the peripheral's bus slave port.

## Interface
- `DATA_WIDTH`, 32, bus data width.
- `ADDR_WIDTH`, 32, bus address width.
- `SCRIPT_AW`, 6, script ROM address width (64 entries).
- `TIMEOUT`, 255, maximum cycles to wait for `bus_ack`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse that begins a script run from entry 0.
- `script_addr`  out  SCRIPT_AW  ROM index of the current step.
- `script_word`  in  2+ADDR_WIDTH+2*DATA_WIDTH  fields from MSB: op[1:0], addr, data, mask. Combinational from `script_addr`.
- `bus_valid`  out  1  request valid.
- `bus_read`  out  1  read request.
- `bus_write`  out  1  write request.
- `bus_addr`  out  ADDR_WIDTH  request address.
- `bus_wdata`  out  DATA_WIDTH  write data.
- `bus_rdata`  in  DATA_WIDTH  read data, valid when `bus_ack`=1.
- `bus_ack`  in  1  slave completion.
- `done`  out  1  run finished (sticky until next `start`).
- `error`  out  1  at least one check failed or a timeout occurred (sticky).
- `timeout`  out  1  run aborted on bus timeout.
- `fail_index`  out  SCRIPT_AW  script index of the first failure.

## Operation
- Op codes: 0 END, 1 WRITE, 2 READ_CHECK, 3 WAIT (cycles = data[15:0]).
- States: IDLE, FETCH, WAIT_ACK, DELAY, DONE.
- Reset: state IDLE. All outputs are 0, including `script_addr`, bus signals, `done`, `error`, `timeout` and `fail_index`.
- IDLE/DONE + `start`=1: clear `done`, `error`, `timeout` and `fail_index`; set `script_addr`=0; go to FETCH. `start` is ignored in every other state.
- FETCH decodes `script_word`:
  - END: `done`=1, go to DONE.
  - WRITE: register addr/data onto the bus, set `bus_valid`=1 and `bus_write`=1, go to WAIT_ACK.
  - READ_CHECK: same as WRITE, but with `bus_read`=1 instead of `bus_write`.
  - WAIT: load the delay counter with data[15:0], go to DELAY. A count of 0 advances immediately.
- WAIT_ACK:
  - Request signals hold stable until `bus_ack` is sampled high.
  - On ack, drop `bus_valid`, `bus_read` and `bus_write`.
  - For READ_CHECK, if (`bus_rdata` & mask) != (data & mask), set `error`. If this is the first failure, latch `fail_index`=`script_addr`.
  - A mismatch does not abort the run. Advance to the next step.
- Timeout: a wait counter clears on entering WAIT_ACK and increments each cycle without ack. When it reaches `TIMEOUT`:
  - drop the request signals;
  - set `error`=1 and `timeout`=1;
  - latch `fail_index` if it is the first failure;
  - set `done`=1 and go to DONE.
- DELAY: decrement each cycle. At 1, advance.
- Advance: if `script_addr` = 2^SCRIPT_AW−1, treat it as an implicit END (`done`=1, DONE). Otherwise increment `script_addr` and go to FETCH. The address never wraps.
- Ack arriving while `bus_valid`=0 is ignored.

## Timing
- `start` sampled at edge N: FETCH at N+1, `script_addr`=0 valid from N+1.
- WRITE/READ: `bus_valid` high from edge N+2.
- Ack sampled at edge M: `bus_valid` low and FETCH of the next step after M. Each bus step costs 1 cycle (FETCH) plus the number of cycles `bus_valid` is high.
- Ack on the first valid cycle gives a minimum of 2 cycles per bus step.
- WAIT n (n≥1) occupies 1 + n cycles. WAIT 0 occupies 1 cycle.
- `done`, `error`, `timeout` and `fail_index` are registered and change only on the edges described above.
- `reset_n` low at any time, including mid-transaction, forces the reset state asynchronously. `bus_valid` drops immediately.

## Test plan
- Write-then-read happy path. Script: WRITE 0x10←0xA5A5; READ_CHECK 0x10 data 0xA5A5 mask 0xFFFF; END. Slave acks at once and returns 0xA5A5. Expect `done`=1, `error`=0, and END reached 5 cycles after FETCH of step 0.
- Masked mismatch. READ_CHECK at step 3 with mask 0x00FF, expected 0x12, rdata 0x3412 → no error. Same check at step 4 with rdata 0x3413 → `error`=1, `fail_index`=4, run continues to END, `done`=1.
- Timeout. Slave never acks on step 2 with `TIMEOUT`=8. Expect `bus_valid` high for exactly 8 cycles, then `timeout`=1, `error`=1, `fail_index`=2, `done`=1.
- Delay and script end. WAIT 5 measures 6 cycles between consecutive FETCHes. A full 64-entry script with no END sets `done`=1 after step 63, and `script_addr` stays 63.
- Reset and restart:
  - `reset_n` low while `bus_valid`=1 gives all outputs 0 within the same cycle.
  - A `start` while busy is ignored.
  - A `start` in DONE clears `error` and reruns from entry 0.
